// File: rtl/fir_stream_pkg.sv
// Shared constants for the FIR output stream path.
// Holds default widths, saturation bounds, the output FIFO depth and the
// FIR pipeline latency that sizes the ready watermark. It also provides a
// helper that maps a decimation ratio of 0 to 1.
package fir_stream_pkg;

  localparam int IN_WIDTH_DEF   = 32;
  localparam int OUT_WIDTH_DEF  = 16;
  localparam int FIFO_DEPTH_DEF = 64;

  // Saturation bounds for the default output width.
  localparam int SAT_MAX = (2 ** (OUT_WIDTH_DEF - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (OUT_WIDTH_DEF - 1));

  // The FIR keeps producing samples for this many clocks after tready drops.
  localparam int FIR_LATENCY = 23;
  // Extra headroom on top of the FIR latency: two round/saturate stages,
  // one clock of lag in the registered watermark, and two spare entries.
  localparam int READY_MARGIN_DEF = FIR_LATENCY + 5;

  // A ratio of 0 means "keep every sample", which is the same as a ratio of 1.
  function automatic logic [7:0] eff_ratio(input logic [7:0] r);
    return (r == 8'd0) ? 8'd1 : r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
// rd_data_o always shows the head entry while empty_o is low. A write to a
// full FIFO succeeds only if a read happens in the same cycle.
// Ports: clk_i, rst_i (sync, active high), wr_en_i/wr_data_i,
//        rd_en_i/rd_data_o, empty_o, full_o, count_o (fill level).
module sync_fifo_fwft #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr, w_rd;

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == (AW+1)'(DEPTH));
  assign count_o   = r_count;
  assign rd_data_o = r_mem[r_rd_ptr];

  assign w_rd = rd_en_i && !empty_o;
  // On a full FIFO, a same-cycle pop frees the slot the write lands in.
  assign w_wr = wr_en_i && (!full_o || w_rd);

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fir_decim_sat.sv
// Post-FIR stage. It rounds and shifts the 32-bit FIR product, saturates it
// to OUT_WIDTH, keeps 1 of every N samples, and buffers the kept samples in
// a FWFT FIFO for an AXIS consumer.
// Ports: clk_i, rst_i (sync, active high); s_axis_* FIR input, which is
//        always accepted; s_axis_tready_o is the registered watermark fed back
//        to the FIR; dec_ratio_i, shift_i and ovf_clr_i are runtime controls;
//        m_axis_* is the output stream; overflow_o is a sticky drop flag.
// Build option FIR_DECIM_STATS_EN adds sat_cnt_o and drop_cnt_o.
module fir_decim_sat
  import fir_stream_pkg::*;
#(
  parameter int IN_WIDTH     = IN_WIDTH_DEF,
  parameter int OUT_WIDTH    = OUT_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int READY_MARGIN = READY_MARGIN_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata_i,
  input  logic                 s_axis_tvalid_i,
  input  logic                 s_axis_tlast_i,
  output logic                 s_axis_tready_o,
  input  logic [7:0]           dec_ratio_i,
  input  logic [4:0]           shift_i,
  input  logic                 ovf_clr_i,
  output logic [OUT_WIDTH-1:0] m_axis_tdata_o,
  output logic                 m_axis_tvalid_o,
  output logic                 m_axis_tlast_o,
  input  logic                 m_axis_tready_i,
`ifdef FIR_DECIM_STATS_EN
  output logic [15:0]          sat_cnt_o,
  output logic [15:0]          drop_cnt_o,
`endif
  output logic                 overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [IN_WIDTH:0] SMAX = (IN_WIDTH+1)'((2 ** (OUT_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH:0] SMIN = (IN_WIDTH+1)'(-(2 ** (OUT_WIDTH-1)));

  // Round and shift. The 33-bit intermediate cannot wrap for shifts up to 31.
  logic signed [IN_WIDTH:0] w_ext, w_bias, w_rnd;
  assign w_ext  = {s_axis_tdata_i[IN_WIDTH-1], s_axis_tdata_i};
  assign w_bias = (IN_WIDTH+1)'(1) << (shift_i - 5'd1);
  always_comb begin
    w_rnd = w_ext;
    if (shift_i != 5'd0) w_rnd = (w_ext + w_bias) >>> shift_i;
  end

  // Decimation. The ratio is latched only at the start of a period.
  logic [7:0] r_cnt, r_ratio, w_eff;
  logic       w_keep;
  assign w_eff  = (r_cnt == 8'd0) ? eff_ratio(dec_ratio_i) : r_ratio;
  assign w_keep = (r_cnt == 8'd0) || s_axis_tlast_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= 8'd0;
      r_ratio <= 8'd1;
    end else if (s_axis_tvalid_i) begin
      if (r_cnt == 8'd0) r_ratio <= w_eff;
      if (s_axis_tlast_i || (r_cnt == w_eff - 8'd1)) r_cnt <= 8'd0;
      else                                           r_cnt <= r_cnt + 8'd1;
    end
  end

  // Stage 1: the rounded value. Only kept samples are marked valid.
  logic                     r_s1_vld, r_s1_last;
  logic signed [IN_WIDTH:0] r_s1_data;
  // Stage 2: the saturated word to be pushed into the FIFO.
  logic                     r_s2_vld, r_s2_last, r_s2_sat;
  logic [OUT_WIDTH-1:0]     r_s2_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_data <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_sat  <= 1'b0;
      r_s2_data <= '0;
    end else begin
      r_s1_vld  <= s_axis_tvalid_i && w_keep;
      r_s1_last <= s_axis_tlast_i;
      r_s1_data <= w_rnd;
      r_s2_vld  <= r_s1_vld;
      r_s2_last <= r_s1_last;
      r_s2_sat  <= (r_s1_data > SMAX) || (r_s1_data < SMIN);
      if (r_s1_data > SMAX)      r_s2_data <= {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (r_s1_data < SMIN) r_s2_data <= {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                       r_s2_data <= r_s1_data[OUT_WIDTH-1:0];
    end
  end

  logic [OUT_WIDTH:0] w_rd_word;
  logic               w_empty, w_full, w_pop, w_drop;
  logic [AW:0]        w_count;

  sync_fifo_fwft #(.WIDTH(OUT_WIDTH+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (r_s2_vld),
    .wr_data_i ({r_s2_last, r_s2_data}),
    .rd_en_i   (m_axis_tready_i),
    .rd_data_o (w_rd_word),
    .empty_o   (w_empty),
    .full_o    (w_full),
    .count_o   (w_count)
  );

  assign w_pop  = !w_empty && m_axis_tready_i;
  assign w_drop = r_s2_vld && w_full && !w_pop;

  // Gate the stale memory contents so that an empty FIFO presents zeros.
  assign m_axis_tvalid_o = !w_empty;
  assign m_axis_tdata_o  = w_empty ? '0 : w_rd_word[OUT_WIDTH-1:0];
  assign m_axis_tlast_o  = !w_empty && w_rd_word[OUT_WIDTH];

  logic r_rdy, r_ovf;
  assign s_axis_tready_o = r_rdy;
  assign overflow_o      = r_ovf;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdy <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_rdy <= (w_count < (AW+1)'(FIFO_DEPTH - READY_MARGIN));
      // A new drop takes priority over a clear in the same cycle.
      if (w_drop)         r_ovf <= 1'b1;
      else if (ovf_clr_i) r_ovf <= 1'b0;
    end
  end

`ifdef FIR_DECIM_STATS_EN
  logic [15:0] r_sat_cnt, r_drop_cnt;
  assign sat_cnt_o  = r_sat_cnt;
  assign drop_cnt_o = r_drop_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || ovf_clr_i) begin
      r_sat_cnt  <= 16'd0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (r_s2_vld && r_s2_sat && (r_sat_cnt != 16'hFFFF)) r_sat_cnt  <= r_sat_cnt + 16'd1;
      if (w_drop && (r_drop_cnt != 16'hFFFF))              r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_decim_sat.sv
module tb_fir_decim_sat;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] s_axis_tdata_i;
  logic        s_axis_tvalid_i, s_axis_tlast_i, s_axis_tready_o;
  logic [7:0]  dec_ratio_i;
  logic [4:0]  shift_i;
  logic        ovf_clr_i;
  logic [15:0] m_axis_tdata_o;
  logic        m_axis_tvalid_o, m_axis_tlast_o, m_axis_tready_i;
  logic        overflow_o;
`ifdef FIR_DECIM_STATS_EN
  logic [15:0] sat_cnt_o, drop_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  fir_decim_sat dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tvalid_i(s_axis_tvalid_i),
    .s_axis_tlast_i(s_axis_tlast_i), .s_axis_tready_o(s_axis_tready_o),
    .dec_ratio_i(dec_ratio_i), .shift_i(shift_i), .ovf_clr_i(ovf_clr_i),
    .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tlast_o(m_axis_tlast_o), .m_axis_tready_i(m_axis_tready_i),
`ifdef FIR_DECIM_STATS_EN
    .sat_cnt_o(sat_cnt_o), .drop_cnt_o(drop_cnt_o),
`endif
    .overflow_o(overflow_o)
  );

  int n_chk = 0, n_err = 0;

  typedef struct { int d; bit l; } smp_t;
  smp_t exp_q[$];
  smp_t got_q[$];

  // Reference decimator state: position inside the current keep period.
  int m_pos, m_period;
  int shift_v, ratio_v;

  typedef struct { int d; bit l; int sh; int exp_d; bit exp_l; } vec_t;
  vec_t tv[8];

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Round half up on the scaled value, then clamp to the signed 16-bit range.
  function automatic int ref_val(input int d, input int sh);
    longint v;
    v = longint'(d);
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pos = 0;
    m_period = 1;
  endtask

  task automatic model_in(input int d, input bit last);
    smp_t e;
    if (m_pos == 0) m_period = (ratio_v == 0) ? 1 : ratio_v;
    if (m_pos == 0 || last) begin
      e.d = ref_val(d, shift_v);
      e.l = last;
      exp_q.push_back(e);
    end
    m_pos = (last || m_pos + 1 >= m_period) ? 0 : m_pos + 1;
  endtask

  // Drive one cycle, score any pop that the next edge performs, then advance.
  task automatic run_cycle(input bit vld, input int data, input bit last);
    smp_t g, e;
    s_axis_tvalid_i = vld;
    s_axis_tdata_i  = data;
    s_axis_tlast_i  = last & vld;
    shift_i         = 5'(shift_v);
    dec_ratio_i     = 8'(ratio_v);
    if (vld) model_in(data, last);
    if (m_axis_tvalid_o && m_axis_tready_i) begin
      g.d = int'($signed(m_axis_tdata_o));
      g.l = m_axis_tlast_o;
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_output: got %0d expected none", g.d);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", g.d, e.d);
        chk("out_last", g.l, e.l);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic drain(input int cycles);
    m_axis_tready_i = 1'b1;
    repeat (cycles) run_cycle(1'b0, 0, 1'b0);
    chk("leftover_expected", exp_q.size(), 0);
  endtask

  initial begin
    int lat, sent;
    int exp3 [4] = '{0, 4, 8, 9};
    rst_i = 1'b1; s_axis_tvalid_i = 1'b0; s_axis_tlast_i = 1'b0; s_axis_tdata_i = '0;
    dec_ratio_i = 8'd1; shift_i = 5'd0; ovf_clr_i = 1'b0; m_axis_tready_i = 1'b0;
    shift_v = 0; ratio_v = 1;
    model_reset();

    tv[0] = '{100,        0, 0, 100,    0};
    tv[1] = '{-5,         0, 0, -5,     0};
    tv[2] = '{32767,      1, 0, 32767,  1};
    tv[3] = '{24,         0, 4, 2,      0};
    tv[4] = '{23,         0, 4, 1,      0};
    tv[5] = '{-24,        0, 4, -1,     0};
    tv[6] = '{1120000,    0, 4, 32767,  0};
    tv[7] = '{-640000,    1, 4, -32768, 1};

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_m_tvalid", m_axis_tvalid_o, 0);
    chk("rst_m_tdata", m_axis_tdata_o, 0);
    chk("rst_m_tlast", m_axis_tlast_o, 0);
    chk("rst_s_tready", s_axis_tready_o, 0);
    chk("rst_overflow", overflow_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("s_tready_after_rst", s_axis_tready_o, 1);

    // Tests 1 and 2: table-driven single samples with a 3-clock latency, ratio 1.
    m_axis_tready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid_i = 1'b1;
      s_axis_tdata_i  = tv[i].d;
      s_axis_tlast_i  = tv[i].l;
      shift_i         = 5'(tv[i].sh);
      @(negedge clk_i);
      s_axis_tvalid_i = 1'b0; s_axis_tlast_i = 1'b0;
      lat = 1;
      while (!m_axis_tvalid_o && lat < 10) begin @(negedge clk_i); lat++; end
      chk("latency", lat, 3);
      chk("vec_data", int'($signed(m_axis_tdata_o)), tv[i].exp_d);
      chk("vec_last", m_axis_tlast_o, tv[i].exp_l);
      @(negedge clk_i);
      chk("vec_popped", m_axis_tvalid_o, 0);
    end

    // Test 3: ratio 4. The frame end forces a keep and restarts the count.
    shift_v = 0; ratio_v = 4; got_q.delete();
    for (int i = 0; i < 10; i++) run_cycle(1'b1, i, i == 9);
    drain(10);
    chk("dec_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      chk("dec_val", got_q[i].d, exp3[i]);
      chk("dec_last", got_q[i].l, i == 3);
    end
    got_q.delete();
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 100 + i, i == 4);
    drain(10);
    chk("frame2_count", got_q.size(), 2);
    if (got_q.size() > 0) chk("frame2_first", got_q[0].d, 100);

    // Test 4: consumer stalled. The watermark drops at fill 36 (two pipe
    // stages plus one registered clock), then 24 in-flight samples follow.
    ratio_v = 1; m_axis_tready_i = 1'b0; sent = 0;
    while (s_axis_tready_o && sent < 200) begin run_cycle(1'b1, sent, 1'b0); sent++; end
    chk("ready_fall_after", sent, 39);
    for (int i = 0; i < 24; i++) begin run_cycle(1'b1, sent, 1'b0); sent++; end
    repeat (4) run_cycle(1'b0, 0, 1'b0);
    chk("t4_overflow", overflow_o, 0);
    chk("t4_ready_low", s_axis_tready_o, 0);
    got_q.delete();
    drain(80);
    chk("t4_drained", got_q.size(), 63);

    // Test 5: 70 forced pushes into a 64-entry FIFO.
    m_axis_tready_i = 1'b0;
    for (int i = 0; i < 70; i++) begin
      run_cycle(1'b1, 1000 + i, 1'b0);
      if (i == 65) chk("ovf_before_drop", overflow_o, 0);
      if (i == 66) chk("ovf_after_drop", overflow_o, 1);
    end
    while (exp_q.size() > 64) void'(exp_q.pop_back());
    repeat (3) run_cycle(1'b0, 0, 1'b0);
    chk("ovf_sticky", overflow_o, 1);
`ifdef FIR_DECIM_STATS_EN
    chk("drop_cnt", drop_cnt_o, 6);
    chk("sat_cnt", sat_cnt_o, 0);
`endif
    ovf_clr_i = 1'b1; run_cycle(1'b0, 0, 1'b0); ovf_clr_i = 1'b0;
    chk("ovf_cleared", overflow_o, 0);
    // Drop and clear land on the same edge; the drop must win.
    run_cycle(1'b1, 5555, 1'b0);
    void'(exp_q.pop_back());
    run_cycle(1'b0, 0, 1'b0);
    ovf_clr_i = 1'b1; run_cycle(1'b0, 0, 1'b0); ovf_clr_i = 1'b0;
    chk("ovf_set_wins", overflow_o, 1);
    got_q.delete();
    drain(80);
    chk("t5_drained", got_q.size(), 64);

    // Test 6: reset mid-frame with 10 entries buffered and one in flight.
    m_axis_tready_i = 1'b0;
    for (int i = 0; i < 10; i++) run_cycle(1'b1, 200 + i, 1'b0);
    repeat (2) run_cycle(1'b0, 0, 1'b0);
    chk("t6_tvalid_pre", m_axis_tvalid_o, 1);
    chk("t6_ovf_pre", overflow_o, 1);
    run_cycle(1'b1, 299, 1'b0);
    rst_i = 1'b1; s_axis_tvalid_i = 1'b0;
    @(negedge clk_i);
    chk("t6_tvalid_rst", m_axis_tvalid_o, 0);
    chk("t6_ovf_rst", overflow_o, 0);
    rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    ratio_v = 3; got_q.delete();
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 50 + i, i == 5);
    drain(12);
    chk("t6_count", got_q.size(), 3);
    if (got_q.size() > 0) chk("t6_first", got_q[0].d, 50);

    // Random traffic against the reference model, respecting the watermark.
    for (int c = 0; c < 2000; c++) begin
      bit v;
      m_axis_tready_i = ($urandom_range(3) != 0);
      if ($urandom_range(19) == 0) ratio_v = $urandom_range(5);
      shift_v = $urandom_range(24);
      v = s_axis_tready_o && ($urandom_range(2) != 0);
      run_cycle(v, int'($urandom), $urandom_range(9) == 0);
    end
    drain(100);
    chk("rand_overflow", overflow_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
